// File: rtl/sha256_msg_pad.sv
// SHA-256 message padder: collects up to MAX_WORDS 32-bit words and emits one or two padded 512-bit blocks.
// Define MSGPAD_BYTESWAP_EN to byte-reverse every data word before it is stored.
module sha256_msg_pad #(
  parameter int MAX_WORDS  = 29,
  parameter int SINGLE_MAX = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [1023:0] message,
  output logic          two_block,
  output logic          msg_valid,
  input  logic          msg_ready,
  output logic          err
);

  typedef enum logic [2:0] {
    COLLECT,
    PAD,
    ZERO,
    LEN_HI,
    LEN_LO,
    OUT,
    DRAIN
  } stateT;

  localparam logic [4:0] LAST_DATA_IDX = 5'(MAX_WORDS - 1);
  localparam logic [4:0] SINGLE_LIMIT  = 5'(SINGLE_MAX);

  stateT       state;
  stateT       nextState;
  logic [4:0]  cnt;
  logic [4:0]  ptr;
  logic [4:0]  lastIdx;
  logic        xfer;
  logic        padHasZeros;
  logic        wrEn;
  logic [4:0]  wrIdx;
  logic [31:0] wrData;
  logic [31:0] inWord;

`ifdef MSGPAD_BYTESWAP_EN
  assign inWord = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
  assign inWord = in_data;
`endif

  // The length word sits at the end of whichever block closes the message.
  assign lastIdx     = two_block ? 5'd31 : 5'd15;
  assign xfer        = in_valid && in_ready;
  assign padHasZeros = ({1'b0, cnt} + 6'd1) <= ({1'b0, lastIdx} - 6'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      COLLECT: begin
        if (xfer) begin
          if (in_last) begin
            nextState = PAD;
          end else if (cnt == LAST_DATA_IDX) begin
            nextState = DRAIN;
          end
        end
      end
      PAD:     nextState = padHasZeros ? ZERO : LEN_HI;
      ZERO:    nextState = (ptr == lastIdx - 5'd2) ? LEN_HI : ZERO;
      LEN_HI:  nextState = LEN_LO;
      LEN_LO:  nextState = OUT;
      OUT:     nextState = msg_ready ? COLLECT : OUT;
      DRAIN:   nextState = (xfer && in_last) ? COLLECT : DRAIN;
      default: nextState = COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    msg_valid = 1'b0;
    wrEn      = 1'b0;
    wrIdx     = cnt;
    wrData    = 32'd0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        wrEn     = in_valid;
        wrData   = inWord;
      end
      PAD: begin
        wrEn   = 1'b1;
        wrData = 32'h8000_0000;
      end
      ZERO: begin
        wrEn  = 1'b1;
        wrIdx = ptr;
      end
      LEN_HI: begin
        wrEn  = 1'b1;
        wrIdx = lastIdx - 5'd1;
      end
      LEN_LO: begin
        wrEn   = 1'b1;
        wrIdx  = lastIdx;
        wrData = {22'd0, cnt, 5'd0};
      end
      OUT:     msg_valid = 1'b1;
      DRAIN:   in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // cnt holds the data-word count once collection ends; ptr walks the zero fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 5'd0;
      ptr       <= 5'd0;
      message   <= '0;
      two_block <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        if (wrEn && wrIdx == 5'(i)) begin
          message[1023-32*i -: 32] <= wrData;
        end
      end
      case (state)
        COLLECT: begin
          if (xfer) begin
            cnt <= cnt + 5'd1;
            if (in_last) begin
              two_block <= (cnt >= SINGLE_LIMIT);
            end
          end
        end
        PAD:  ptr <= cnt + 5'd1;
        ZERO: ptr <= ptr + 5'd1;
        OUT: begin
          if (msg_ready) begin
            message   <= '0;
            cnt       <= 5'd0;
            two_block <= 1'b0;
          end
        end
        DRAIN: begin
          if (xfer && in_last) begin
            err       <= 1'b1;
            message   <= '0;
            cnt       <= 5'd0;
            two_block <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
